// File: rtl/adders_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adders_pkg
//  Description : Shared types, helpers and constants for the fas_vec_* adder
//                family.
//  Revision    : 1.0 - initial release
// ============================================================================
package adders_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Signed limits at the widest supported width; narrower users take the
    // top WIDTH bits, which keeps the sign pattern intact.
    localparam int          C_SAT_W    = 64;
    localparam logic [63:0] C_SAT_SMAX = {1'b0, {63{1'b1}}};
    localparam logic [63:0] C_SAT_SMIN = {1'b1, {63{1'b0}}};

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fas_chunk_cla.sv
`default_nettype none
// ============================================================================
//  Module      : fas_chunk_cla
//  Description : CW-bit combinational generate/propagate adder for one chunk;
//                also exposes the carry into the chunk MSB for overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module fas_chunk_cla #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] z,
    output logic          cout,
    output logic          c_msb
);

    logic [CW-1:0] w_g;
    logic [CW-1:0] w_p;
    logic [CW:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < CW; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign z     = w_p ^ w_c[CW-1:0];
    assign cout  = w_c[CW];
    assign c_msb = w_c[CW-1];

endmodule
`default_nettype wire

// File: rtl/fas_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fas_vec_pipe
//  Description : Pipelined WIDTH-bit add/subtract, one CW-bit chunk per stage,
//                valid/ready with bubble collapsing. Optional saturation is
//                enabled by defining FAS_VEC_PIPE_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fas_vec_pipe
    import adders_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             add_nsub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int CW   = chunk_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_err
        $error("fas_vec_pipe: WIDTH must be divisible by STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_a    [STAGES];
    logic [WIDTH-1:0]  r_b    [STAGES];
    logic [WIDTH-1:0]  r_z    [STAGES];
    logic              r_c    [STAGES];
    logic              r_cmsb [STAGES];
    op_e               r_op   [STAGES];

    logic              w_load    [STAGES];
    logic              w_src_v   [STAGES];
    logic [WIDTH-1:0]  w_src_a   [STAGES];
    logic [WIDTH-1:0]  w_src_b   [STAGES];
    logic [WIDTH-1:0]  w_src_z   [STAGES];
    logic              w_src_c   [STAGES];
    op_e               w_src_op  [STAGES];
    logic [CW-1:0]     w_chunk_z [STAGES];
    logic [WIDTH-1:0]  w_nxt_z   [STAGES];
    logic              w_nxt_c   [STAGES];
    logic              w_nxt_cmsb[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // A stage can take new content if it or any stage downstream of it
        // has a hole, or the output is being drained this cycle.
        assign w_load[s] = out_ready || !(&r_v[LAST:s]);

        if (s == 0) begin : g_head
            assign w_src_v[s]  = in_valid;
            assign w_src_a[s]  = a;
            assign w_src_b[s]  = b ^ {WIDTH{add_nsub}};
            assign w_src_z[s]  = '0;
            assign w_src_c[s]  = cin ^ add_nsub;
            assign w_src_op[s] = op_e'(add_nsub);
        end else begin : g_body
            assign w_src_v[s]  = r_v[s-1];
            assign w_src_a[s]  = r_a[s-1];
            assign w_src_b[s]  = r_b[s-1];
            assign w_src_z[s]  = r_z[s-1];
            assign w_src_c[s]  = r_c[s-1];
            assign w_src_op[s] = r_op[s-1];
        end

        fas_chunk_cla #(
            .CW (CW)
        ) u_cla (
            .a     (w_src_a[s][s*CW +: CW]),
            .b     (w_src_b[s][s*CW +: CW]),
            .cin   (w_src_c[s]),
            .z     (w_chunk_z[s]),
            .cout  (w_nxt_c[s]),
            .c_msb (w_nxt_cmsb[s])
        );

        always_comb begin
            w_nxt_z[s]            = w_src_z[s];
            w_nxt_z[s][s*CW +: CW] = w_chunk_z[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_a[s]    <= '0;
                r_b[s]    <= '0;
                r_z[s]    <= '0;
                r_c[s]    <= 1'b0;
                r_cmsb[s] <= 1'b0;
                r_op[s]   <= OP_ADD;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_load[s]) begin
                    r_v[s]    <= w_src_v[s];
                    r_a[s]    <= w_src_a[s];
                    r_b[s]    <= w_src_b[s];
                    r_z[s]    <= w_nxt_z[s];
                    r_c[s]    <= w_nxt_c[s];
                    r_cmsb[s] <= w_nxt_cmsb[s];
                    r_op[s]   <= w_src_op[s];
                end
            end
        end
    end

    assign in_ready  = rst_n && w_load[0];
    assign out_valid = r_v[LAST];
    assign cout      = r_c[LAST] ^ (r_op[LAST] == OP_SUB);
    assign ovf       = r_cmsb[LAST] ^ r_c[LAST];

`ifdef FAS_VEC_PIPE_SAT_EN
    if (WIDTH > C_SAT_W) begin : g_sat_err
        $error("fas_vec_pipe: saturation supports WIDTH up to 64");
    end

    localparam logic [WIDTH-1:0] C_SMAX = C_SAT_SMAX[C_SAT_W-1 -: WIDTH];
    localparam logic [WIDTH-1:0] C_SMIN = C_SAT_SMIN[C_SAT_W-1 -: WIDTH];

    // The first operand's sign tells which limit was overrun.
    assign z = ovf ? (r_a[LAST][WIDTH-1] ? C_SMIN : C_SMAX) : r_z[LAST];
`else
    assign z = r_z[LAST];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fas_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fas_vec_pipe
//  Description : Directed-vector bench for fas_vec_pipe (WIDTH=16, STAGES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fas_vec_pipe;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         add_nsub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;

    fas_vec_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .add_nsub  (add_nsub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    bit           chk_lat = 1'b0;
    bit           hold_v  = 1'b0;
    logic [W-1:0] hold_z;
    logic [1:0]   hold_co;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] wz, input logic [W-1:0] sz,
                                input logic c, input logic o);
        exp_t e;
`ifdef FAS_VEC_PIPE_SAT_EN
        e.z = sz;
`else
        e.z = wz;
`endif
        e.c   = c;
        e.o   = o;
        e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic is);
        exp_t       e;
        logic [W:0] r;
        if (!is) begin
            r   = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
            e.o = (ia[W-1] == ib[W-1]) && (r[W-1] != ia[W-1]);
        end else begin
            r   = {1'b0, ia} - {1'b0, ib} - (W+1)'(ic);
            e.o = (ia[W-1] != ib[W-1]) && (r[W-1] != ia[W-1]);
        end
        e.z = r[W-1:0];
        e.c = r[W];
`ifdef FAS_VEC_PIPE_SAT_EN
        if (e.o) e.z = ia[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.cyc = 0;
        return e;
    endfunction

    // Offer one beat until accepted; inputs change only just after posedge.
    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic is, input exp_t ex, output bit stalled);
        int   n   = 0;
        bit   acc = 1'b0;
        exp_t e   = ex;
        a = ia; b = ib; cin = ic; add_nsub = is; in_valid = 1'b1;
        stalled = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.cyc = cyc;
                q.push_back(e);
            end else begin
                stalled = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold_v) begin
                chk("hold_z", z, hold_z);
                chk("hold_cout_ovf", {cout, ovf}, hold_co);
            end
            hold_v  = out_valid && !out_ready;
            hold_z  = z;
            hold_co = {cout, ovf};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("z", z, e.z);
                    chk("cout", cout, e.c);
                    chk("ovf", ovf, e.o);
                    if (chk_lat) chk("latency", cyc - e.cyc, S);
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit           st;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        add_nsub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_z", z, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors, back to back, no stall.
        chk_lat = 1'b1;
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, mk(16'h2233, 16'h2233, 1'b0, 1'b0), st);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 16'hFFFE, 1'b1, 1'b0), st);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 16'h0000, 1'b1, 1'b0), st);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 16'h7FFF, 1'b0, 1'b1), st);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 16'h8000, 1'b0, 1'b1), st);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 16'h8000, 1'b1, 1'b1), st);
        send(16'h0000, 16'h0000, 1'b1, 1'b1, mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0), st);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 16'h0100, 1'b0, 1'b0), st);
        drain();

        // Ten random ops with output stalled for four cycles.
        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = W'($urandom); rb = W'($urandom);
                    rc = 1'($urandom); rs = 1'($urandom);
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs), st);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("ready_when_full", in_ready, 0);
                chk("valid_when_full", out_valid, 1);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Continuous streaming: every beat accepted on first offer.
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), st);
            chk("stream_no_stall", st, 0);
        end
        drain();

        // Reset with three ops in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(16'h1111 * 16'(i + 1), 16'h0001, 1'b0, 1'b0,
                 model(16'h1111 * 16'(i + 1), 16'h0001, 1'b0, 1'b0), st);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(16'h4000, 16'h0123, 1'b1, 1'b1, mk(16'h3EDC, 16'h3EDC, 1'b0, 1'b0), st);
        drain();
        repeat (6) @(posedge clk);
        #1;
        chk("final_empty", q.size(), 0);
        chk("final_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
